// File: rtl/isa_pkg.sv
// Shared ISA constants for the decode stage and the ALU: R-type opcode, funct codes and ALU op codes.
// decode() maps an instruction's opcode/funct onto the ALU op code and an illegal flag.
package isa_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_REG_N  = 32;

  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_GT   = 6'h2A;

  typedef enum logic [2:0] {
    ALUOP_AND = 3'b000,
    ALUOP_OR  = 3'b001,
    ALUOP_ADD = 3'b010,
    ALUOP_SUB = 3'b110,
    ALUOP_GT  = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    illegal;
  } decode_t;

  // Illegal encodings report ALUOP_AND so the consumer sees a harmless op while it traps.
  function automatic decode_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    decode_t d;
    d.alu_op  = ALUOP_AND;
    d.illegal = 1'b0;
    case (funct)
      FUNCT_AND: d.alu_op = ALUOP_AND;
      FUNCT_OR:  d.alu_op = ALUOP_OR;
      FUNCT_ADD: d.alu_op = ALUOP_ADD;
      FUNCT_SUB: d.alu_op = ALUOP_SUB;
      FUNCT_GT:  d.alu_op = ALUOP_GT;
      default:   d.illegal = 1'b1;
    endcase
    if (opcode != OPC_RTYPE) d.illegal = 1'b1;
    if (d.illegal) d.alu_op = ALUOP_AND;
    return d;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundle of the instruction input, write-back port and operand-set output of the fetch stage.
// slave is the stage's view; master is the view of whatever drives it.
interface operand_fetch_stage_if #(
  parameter int DATA_W = isa_pkg::DEF_DATA_W,
  parameter int ADDR_W = isa_pkg::DEF_ADDR_W
);
  logic              InstValid;
  logic              InstReady;
  logic [31:0]       Instr;
  logic              Flush;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] Ope1;
  logic [DATA_W-1:0] Ope2;
  logic [2:0]        AluOp;
  logic [ADDR_W-1:0] DestReg;
  logic              IllegalOp;

  modport slave (
    input  InstValid, Instr, Flush, WrEn, WrAddr, WrData, OutReady,
    output InstReady, OutValid, Ope1, Ope2, AluOp, DestReg, IllegalOp
  );

  modport master (
    output InstValid, Instr, Flush, WrEn, WrAddr, WrData, OutReady,
    input  InstReady, OutValid, Ope1, Ope2, AluOp, DestReg, IllegalOp
  );
endinterface

// File: rtl/reg_bank.sv
// Register bank: register 0 reads as zero, one synchronous write port, two combinational
// read ports that forward the write port when it targets the address being read.
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [REG_N];
  logic              wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  // NOTE: the bank is built from flops, so clearing every entry on reset is legal here;
  // a RAM macro could not be reset like this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (wr_live) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0)                  ? '0      :
                     (wr_live && wr_addr == rd_addr_a)  ? wr_data : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0)                  ? '0      :
                     (wr_live && wr_addr == rd_addr_b)  ? wr_data : regs[rd_addr_b];

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage feeding the ALU: decodes R-type instructions, reads operands
// from the register bank and holds them in a single valid/ready output register.
module operand_fetch_stage
  import isa_pkg::*;
#(
  parameter int DATA_W = isa_pkg::DEF_DATA_W,
  parameter int REG_N  = isa_pkg::DEF_REG_N,
  parameter int ADDR_W = isa_pkg::DEF_ADDR_W
) (
  input logic                   Clk,
  input logic                   Rst_n,
  operand_fetch_stage_if.slave  bus
);

  logic              accept;
  decode_t           dec;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              shamt_unused;

  // Shift amount has no meaning for the supported ops.
  assign shamt_unused = ^bus.Instr[10:6];

  assign bus.InstReady = !bus.OutValid || bus.OutReady;
  assign accept        = bus.InstValid && bus.InstReady;
  assign dec           = decode(bus.Instr[31:26], bus.Instr[5:0]);

  reg_bank #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .ADDR_W (ADDR_W)
  ) u_reg_bank (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .wr_en     (bus.WrEn),
    .wr_addr   (bus.WrAddr),
    .wr_data   (bus.WrData),
    .rd_addr_a (bus.Instr[25:21]),
    .rd_addr_b (bus.Instr[20:16]),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b)
  );

  // Flush wins over a same-cycle accept; payload fields only change on a real load.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus.OutValid  <= 1'b0;
      bus.Ope1      <= '0;
      bus.Ope2      <= '0;
      bus.AluOp     <= ALUOP_AND;
      bus.DestReg   <= '0;
      bus.IllegalOp <= 1'b0;
    end else if (bus.Flush) begin
      bus.OutValid  <= 1'b0;
    end else if (accept) begin
      bus.OutValid  <= 1'b1;
      bus.Ope1      <= rd_a;
      bus.Ope2      <= rd_b;
      bus.AluOp     <= dec.alu_op;
      bus.DestReg   <= bus.Instr[15:11];
      bus.IllegalOp <= dec.illegal;
    end else if (bus.OutReady) begin
      bus.OutValid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus randomized traffic
// compared against a register-array/operand-set reference model.
module tb_operand_fetch_stage;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;
  always #5 Clk = ~Clk;

  operand_fetch_stage_if bus ();

  operand_fetch_stage dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ope1;
    logic [31:0] ope2;
    logic [2:0]  op;
    logic [4:0]  dest;
    logic        ill;
  } set_t;

  logic [31:0] m_regs [32];
  bit          m_valid;
  set_t        m_set;

  logic [73:0] out_vec;
  assign out_vec = {bus.OutValid, bus.Ope1, bus.Ope2, bus.AluOp, bus.DestReg, bus.IllegalOp};

  function automatic logic [31:0] mk(input logic [5:0] opc, input int rs, input int rt,
                                     input int rd, input logic [5:0] fn);
    return {opc, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  task automatic model_reset;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_valid = 1'b0;
    m_set   = '{default: '0};
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
    bus.InstValid = iv;
    bus.Instr     = ins;
    bus.Flush     = fl;
    bus.WrEn      = we;
    bus.WrAddr    = wa;
    bus.WrData    = wd;
    bus.OutReady  = ordy;
    #1;
  endtask

  // Advance the model by one clock using the currently driven inputs, then step the DUT.
  task automatic tick;
    logic [5:0] opc, fn;
    logic [4:0] rs, rt;
    bit         acc;
    acc = bus.InstValid && (!m_valid || bus.OutReady);
    if (bus.Flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      opc = bus.Instr[31:26];
      rs  = bus.Instr[25:21];
      rt  = bus.Instr[20:16];
      fn  = bus.Instr[5:0];
      m_valid     = 1'b1;
      m_set.ope1  = (bus.WrEn && bus.WrAddr != 0 && bus.WrAddr == rs) ? bus.WrData : m_regs[rs];
      m_set.ope2  = (bus.WrEn && bus.WrAddr != 0 && bus.WrAddr == rt) ? bus.WrData : m_regs[rt];
      m_set.dest  = bus.Instr[15:11];
      m_set.ill   = 1'b0;
      case (fn)
        6'h24:   m_set.op = 3'b000;
        6'h25:   m_set.op = 3'b001;
        6'h20:   m_set.op = 3'b010;
        6'h22:   m_set.op = 3'b110;
        6'h2A:   m_set.op = 3'b111;
        default: m_set.ill = 1'b1;
      endcase
      if (opc != 6'd0) m_set.ill = 1'b1;
      if (m_set.ill)   m_set.op  = 3'b000;
    end else if (bus.OutReady) begin
      m_valid = 1'b0;
    end
    if (bus.WrEn && bus.WrAddr != 0) m_regs[bus.WrAddr] = bus.WrData;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0, 0, 1);
    #2 Rst_n = 1'b0;
    #1;
    total++;
    if (out_vec !== 74'd0 || bus.InstReady !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got=%h ready=%b exp=0 ready=1", out_vec, bus.InstReady);
    end
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    model_reset();
    drive(0, 0, 0, 1, 5, 32'h55, 1);
    tick();
    drive(1, mk(0, 5, 0, 9, 6'h20), 0, 0, 0, 0, 1);
    tick();
    total++;
    if (bus.OutValid !== 1'b1 || bus.Ope1 !== 32'h55) begin
      bad++;
      $display("FAIL reset_pre got valid=%b ope1=%h exp valid=1 ope1=55", bus.OutValid, bus.Ope1);
    end
    drive(1, mk(0, 5, 0, 9, 6'h22), 0, 0, 0, 0, 0);
    Rst_n = 1'b0;
    #1;
    total++;
    if (bus.OutValid !== 1'b0 || bus.AluOp !== 3'b000 || bus.DestReg !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid got valid=%b op=%b dest=%0d exp 0/000/0",
               bus.OutValid, bus.AluOp, bus.DestReg);
    end
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    drive(1, mk(0, 5, 5, 1, 6'h25), 0, 0, 0, 0, 1);
    tick();
    total++;
    if (out_vec !== {1'b1, 32'd0, 32'd0, 3'b001, 5'd1, 1'b0}) begin
      bad++;
      $display("FAIL reset_reg5 got=%h exp=%h", out_vec, {1'b1, 32'd0, 32'd0, 3'b001, 5'd1, 1'b0});
    end
  endtask

  task automatic test_write_read;
    drive(0, 0, 0, 1, 3, 32'h7, 1);
    tick();
    drive(0, 0, 0, 1, 4, 32'h2, 1);
    tick();
    drive(1, 32'h0064_2820, 0, 0, 0, 0, 1);
    total++;
    if (bus.InstReady !== 1'b1) begin
      bad++;
      $display("FAIL wr_rd_ready got=%b exp=1", bus.InstReady);
    end
    tick();
    total++;
    if (out_vec !== {1'b1, 32'd7, 32'd2, 3'b010, 5'd5, 1'b0}) begin
      bad++;
      $display("FAIL wr_rd got=%h exp=%h", out_vec, {1'b1, 32'd7, 32'd2, 3'b010, 5'd5, 1'b0});
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    total++;
    if (bus.OutValid !== 1'b0) begin
      bad++;
      $display("FAIL wr_rd_drain got valid=%b exp=0", bus.OutValid);
    end
  endtask

  task automatic test_bypass;
    drive(1, mk(0, 3, 4, 6, 6'h22), 0, 1, 3, 32'hDEAD_BEEF, 1);
    tick();
    total++;
    if (out_vec !== {1'b1, 32'hDEAD_BEEF, 32'd2, 3'b110, 5'd6, 1'b0}) begin
      bad++;
      $display("FAIL bypass_rs got=%h exp=%h", out_vec,
               {1'b1, 32'hDEAD_BEEF, 32'd2, 3'b110, 5'd6, 1'b0});
    end
    drive(1, mk(0, 4, 3, 8, 6'h2A), 0, 1, 4, 32'h11, 1);
    tick();
    total++;
    if (out_vec !== {1'b1, 32'h11, 32'hDEAD_BEEF, 3'b111, 5'd8, 1'b0}) begin
      bad++;
      $display("FAIL bypass_rt got=%h exp=%h", out_vec,
               {1'b1, 32'h11, 32'hDEAD_BEEF, 3'b111, 5'd8, 1'b0});
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(0, 3, 4, 10, 6'h24), 0, 0, 0, 0, 0);
      total++;
      if (bus.InstReady !== 1'b0) begin
        bad++;
        $display("FAIL stall_ready cycle=%0d got=%b exp=0", i, bus.InstReady);
      end
      tick();
      total++;
      if (out_vec !== {1'b1, 32'h11, 32'hDEAD_BEEF, 3'b111, 5'd8, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold cycle=%0d got=%h exp=%h", i, out_vec,
                 {1'b1, 32'h11, 32'hDEAD_BEEF, 3'b111, 5'd8, 1'b0});
      end
    end
    drive(1, mk(0, 3, 4, 10, 6'h24), 0, 0, 0, 0, 1);
    total++;
    if (bus.InstReady !== 1'b1) begin
      bad++;
      $display("FAIL stall_release_ready got=%b exp=1", bus.InstReady);
    end
    tick();
    total++;
    if (out_vec !== {1'b1, 32'hDEAD_BEEF, 32'h11, 3'b000, 5'd10, 1'b0}) begin
      bad++;
      $display("FAIL stall_load got=%h exp=%h", out_vec,
               {1'b1, 32'hDEAD_BEEF, 32'h11, 3'b000, 5'd10, 1'b0});
    end
    drive(1, mk(0, 4, 4, 11, 6'h25), 0, 0, 0, 0, 1);
    tick();
    total++;
    if (out_vec !== {1'b1, 32'h11, 32'h11, 3'b001, 5'd11, 1'b0}) begin
      bad++;
      $display("FAIL stall_next got=%h exp=%h", out_vec,
               {1'b1, 32'h11, 32'h11, 3'b001, 5'd11, 1'b0});
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    total++;
    if (bus.OutValid !== 1'b0) begin
      bad++;
      $display("FAIL stall_drain got valid=%b exp=0", bus.OutValid);
    end
  endtask

  task automatic test_decode;
    logic [31:0] ins  [7];
    logic [3:0]  expd [7];
    ins[0] = mk(0, 1, 2, 3, 6'h24);      expd[0] = {3'b000, 1'b0};
    ins[1] = mk(0, 1, 2, 3, 6'h25);      expd[1] = {3'b001, 1'b0};
    ins[2] = mk(0, 1, 2, 3, 6'h20);      expd[2] = {3'b010, 1'b0};
    ins[3] = mk(0, 1, 2, 3, 6'h22);      expd[3] = {3'b110, 1'b0};
    ins[4] = mk(0, 1, 2, 3, 6'h2A);      expd[4] = {3'b111, 1'b0};
    ins[5] = mk(0, 1, 2, 3, 6'h03);      expd[5] = {3'b000, 1'b1};
    ins[6] = mk(6'h08, 1, 2, 3, 6'h22);  expd[6] = {3'b000, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(1, ins[i], 0, 0, 0, 0, 1);
      tick();
      total++;
      if ({bus.OutValid, bus.AluOp, bus.IllegalOp} !== {1'b1, expd[i]}) begin
        bad++;
        $display("FAIL decode idx=%0d got valid/op/ill=%b exp=%b", i,
                 {bus.OutValid, bus.AluOp, bus.IllegalOp}, {1'b1, expd[i]});
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_zero_flush;
    drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1);
    tick();
    drive(1, mk(0, 0, 0, 12, 6'h20), 0, 0, 0, 0, 1);
    tick();
    total++;
    if (out_vec !== {1'b1, 32'd0, 32'd0, 3'b010, 5'd12, 1'b0}) begin
      bad++;
      $display("FAIL zero_reg got=%h exp=%h", out_vec, {1'b1, 32'd0, 32'd0, 3'b010, 5'd12, 1'b0});
    end
    drive(1, mk(0, 0, 0, 13, 6'h20), 0, 1, 0, 32'hFFFF_FFFF, 1);
    tick();
    total++;
    if (bus.Ope1 !== 32'd0 || bus.Ope2 !== 32'd0) begin
      bad++;
      $display("FAIL zero_bypass got ope1=%h ope2=%h exp 0/0", bus.Ope1, bus.Ope2);
    end
    drive(1, mk(0, 3, 4, 14, 6'h20), 1, 1, 7, 32'h1234, 1);
    total++;
    if (bus.InstReady !== 1'b1) begin
      bad++;
      $display("FAIL flush_ready got=%b exp=1", bus.InstReady);
    end
    tick();
    total++;
    if (bus.OutValid !== 1'b0) begin
      bad++;
      $display("FAIL flush_accept got valid=%b exp=0", bus.OutValid);
    end
    drive(1, mk(0, 7, 0, 15, 6'h25), 0, 0, 0, 0, 1);
    tick();
    total++;
    if (out_vec !== {1'b1, 32'h1234, 32'd0, 3'b001, 5'd15, 1'b0}) begin
      bad++;
      $display("FAIL flush_wb got=%h exp=%h", out_vec, {1'b1, 32'h1234, 32'd0, 3'b001, 5'd15, 1'b0});
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    tick();
    total++;
    if (bus.OutValid !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall got valid=%b exp=0", bus.OutValid);
    end
  endtask

  task automatic test_random;
    logic [5:0] functs [5];
    functs[0] = 6'h24; functs[1] = 6'h25; functs[2] = 6'h20; functs[3] = 6'h22; functs[4] = 6'h2A;
    for (int n = 0; n < 3000; n++) begin
      logic        iv, ordy, fl, we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [5:0]  fn, opc;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      we   = $urandom_range(0, 1) == 1;
      wa   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wd   = $urandom;
      fn   = ($urandom_range(0, 4) != 0) ? functs[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      opc  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      drive(iv, mk(opc, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31), fn),
            fl, we, wa, wd, ordy);
      total++;
      if (bus.InstReady !== (!m_valid || ordy)) begin
        bad++;
        $display("FAIL rand_ready n=%0d got=%b exp=%b", n, bus.InstReady, (!m_valid || ordy));
      end
      tick();
      total++;
      if (bus.OutValid !== m_valid ||
          (m_valid && {bus.Ope1, bus.Ope2, bus.AluOp, bus.DestReg, bus.IllegalOp} !==
                      {m_set.ope1, m_set.ope2, m_set.op, m_set.dest, m_set.ill})) begin
        bad++;
        $display("FAIL rand_out n=%0d got=%h exp=%h", n, out_vec,
                 {m_valid, m_set.ope1, m_set.ope2, m_set.op, m_set.dest, m_set.ill});
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_stall();
    test_decode();
    test_zero_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
